// File: rtl/axi_wr_4_scheduler.sv
// axi_wr_4_scheduler
// Arbitration and sequencing controller for a 4-to-1 AXI write merger.
// Picks one of four per-port AW queues, offers it downstream, and records
// W-channel ownership in AW-accept order. It also keeps a per-port count of
// outstanding B responses and stops granting a port whose budget is used up.
//
// Parameters
//   MAXOUT   max outstanding (AW accepted, B not returned) per port, 1..255
//   OQDEPTH  entries in the W-ownership order queue, power of 2
//
// Configuration macro
//   AW_SCHED_PRIO_EN  port a gets strict priority; b..d rotate among themselves
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   req_valid    per-port AW FIFO not empty (bit0=a .. bit3=d)
//   awready      downstream AW ready
//   awvalid      downstream AW valid
//   awid         port tag 1..4 while offering, 0 otherwise
//   aw_sel       AW payload mux select (index of offered port)
//   aw_pop       one-hot pop pulse for the granted port's AW FIFO
//   w_beat_last  downstream wvalid && wready && wlast
//   w_sel        one-hot current W owner, 0 when the order queue is empty
//   b_done       downstream bvalid && bready
//   b_tag        bid accompanying b_done (1..4)
//   outstanding  {d,c,b,a} 8-bit outstanding counts
//   err_sticky   B underflow, bad b_tag, or wlast with no W owner
module axi_wr_4_scheduler #(
    parameter int unsigned MAXOUT  = 8,
    parameter int unsigned OQDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic        awready,
    output logic        awvalid,
    output logic [2:0]  awid,
    output logic [1:0]  aw_sel,
    output logic [3:0]  aw_pop,
    input  logic        w_beat_last,
    output logic [3:0]  w_sel,
    input  logic        b_done,
    input  logic [2:0]  b_tag,
    output logic [31:0] outstanding,
    output logic        err_sticky
);

    localparam int unsigned OqAw = (OQDEPTH > 1) ? $clog2(OQDEPTH) : 1;
    localparam int unsigned OqCw = OqAw + 1;

    typedef enum logic [0:0] {StIdle, StOffer} state_e;

    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        rr_q, rr_d;
    logic [7:0]        cnt_q [4];
    logic [7:0]        cnt_d [4];
    logic [3:0]        oq_q [OQDEPTH];
    logic [OqAw-1:0]   oq_rd_q, oq_rd_d;
    logic [OqAw-1:0]   oq_wr_q, oq_wr_d;
    logic [OqCw-1:0]   oq_cnt_q, oq_cnt_d;
    logic              err_q, err_d;

    logic              oq_full;
    logic              oq_empty;
    logic              oq_push;
    logic              oq_pop;
    logic [3:0]        elig;
    logic [1:0]        winner;
    logic              tag_ok;
    logic [1:0]        b_idx;
    logic              b_ok;
    logic              b_err;

    // First set bit of req strictly after ptr, wrapping 3->0; ptr itself is
    // checked last. Only meaningful when req is non-zero.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    assign oq_empty = (oq_cnt_q == '0);
    assign oq_full  = (oq_cnt_q == OqCw'(OQDEPTH));

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            elig[i] = req_valid[i] && (cnt_q[i] < 8'(MAXOUT)) && !oq_full;
        end
    end

`ifdef AW_SCHED_PRIO_EN
    // Port a preempts; b..d rotate using rr_q, which only b..d grants move.
    assign winner = elig[0] ? 2'd0 : rr_pick({elig[3:1], 1'b0}, rr_q);
`else
    assign winner = rr_pick(elig, rr_q);
`endif

    // Arbitration FSM: next state and AW-side outputs.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        awvalid = 1'b0;
        awid    = 3'd0;
        aw_sel  = 2'd0;
        aw_pop  = 4'b0000;
        oq_push = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|elig) begin
                    sel_d   = winner;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                // Offer is registered, so awvalid never looks at awready.
                awvalid = 1'b1;
                awid    = {1'b0, sel_q} + 3'd1;
                aw_sel  = sel_q;
                if (awready) begin
                    aw_pop[sel_q] = 1'b1;
                    oq_push       = 1'b1;
                    state_d       = StIdle;
`ifdef AW_SCHED_PRIO_EN
                    if (sel_q != 2'd0) begin
                        rr_d = sel_q;
                    end
`else
                    rr_d = sel_q;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Credit counters and error detection.
    assign tag_ok = (b_tag >= 3'd1) && (b_tag <= 3'd4);
    assign b_idx  = 2'(b_tag - 3'd1);
    assign b_ok   = b_done && tag_ok && (cnt_q[b_idx] != 8'd0);
    assign b_err  = b_done && !b_ok;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            unique case ({oq_push && (sel_q == 2'(i)), b_ok && (b_idx == 2'(i))})
                2'b10:   cnt_d[i] = cnt_q[i] + 8'd1;
                2'b01:   cnt_d[i] = cnt_q[i] - 8'd1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // Order queue pointers; a wlast with nothing queued is dropped.
    assign oq_pop = w_beat_last && !oq_empty;

    always_comb begin
        oq_rd_d  = oq_rd_q;
        oq_wr_d  = oq_wr_q;
        oq_cnt_d = oq_cnt_q;
        if (oq_push) begin
            oq_wr_d = (oq_wr_q == OqAw'(OQDEPTH - 1)) ? '0 : oq_wr_q + 1'b1;
        end
        if (oq_pop) begin
            oq_rd_d = (oq_rd_q == OqAw'(OQDEPTH - 1)) ? '0 : oq_rd_q + 1'b1;
        end
        unique case ({oq_push, oq_pop})
            2'b10:   oq_cnt_d = oq_cnt_q + 1'b1;
            2'b01:   oq_cnt_d = oq_cnt_q - 1'b1;
            default: oq_cnt_d = oq_cnt_q;
        endcase
    end

    assign err_d = err_q || b_err || (w_beat_last && oq_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sel_q    <= 2'd0;
            rr_q     <= 2'd3;
            oq_rd_q  <= '0;
            oq_wr_q  <= '0;
            oq_cnt_q <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_q     <= rr_d;
            oq_rd_q  <= oq_rd_d;
            oq_wr_q  <= oq_wr_d;
            oq_cnt_q <= oq_cnt_d;
            err_q    <= err_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Queue storage needs no reset: w_sel masks it while the queue is empty.
    always_ff @(posedge clk) begin
        if (oq_push) begin
            oq_q[oq_wr_q] <= 4'b0001 << sel_q;
        end
    end

    assign w_sel       = oq_empty ? 4'b0000 : oq_q[oq_rd_q];
    assign outstanding = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
    assign err_sticky  = err_q;

endmodule

// File: tb/tb_axi_wr_4_scheduler.sv
// tb_axi_wr_4_scheduler
// Directed bench for axi_wr_4_scheduler. Expected grants go into a queue as
// stimulus is driven; a negedge monitor pops and compares on every aw_pop.
// Define AW_SCHED_PRIO_EN for both files to exercise the priority build.
module tb_axi_wr_4_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic        awready;
    logic        awvalid;
    logic [2:0]  awid;
    logic [1:0]  aw_sel;
    logic [3:0]  aw_pop;
    logic        w_beat_last;
    logic [3:0]  w_sel;
    logic        b_done;
    logic [2:0]  b_tag;
    logic [31:0] outstanding;
    logic        err_sticky;

    int n_checks = 0;
    int n_errors = 0;
    int n_pushed = 0;
    int n_pops   = 0;
    int exp_q[$];
    int sb_e;

    axi_wr_4_scheduler #(
        .MAXOUT (8),
        .OQDEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .awready    (awready),
        .awvalid    (awvalid),
        .awid       (awid),
        .aw_sel     (aw_sel),
        .aw_pop     (aw_pop),
        .w_beat_last(w_beat_last),
        .w_sel      (w_sel),
        .b_done     (b_done),
        .b_tag      (b_tag),
        .outstanding(outstanding),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input int p);
        logic [3:0] one;
        one = 4'b0001;
        return one << p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int p);
        exp_q.push_back(p);
        n_pushed++;
    endtask

    // Retire W ownership as soon as it appears, so the order queue never fills.
    task automatic run_drain(input int n);
        for (int i = 0; i < n; i++) begin
            w_beat_last = (w_sel != 4'b0000);
            tick();
        end
        w_beat_last = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_awvalid"}, 32'(awvalid), 32'd0);
        chk({tag, "_awid"}, 32'(awid), 32'd0);
        chk({tag, "_aw_sel"}, 32'(aw_sel), 32'd0);
        chk({tag, "_aw_pop"}, 32'(aw_pop), 32'd0);
        chk({tag, "_w_sel"}, 32'(w_sel), 32'd0);
        chk({tag, "_outstanding"}, outstanding, 32'd0);
        chk({tag, "_err"}, 32'(err_sticky), 32'd0);
    endtask

    // Scoreboard: every grant pulse must match the oldest expected grant.
    always @(negedge clk) begin
        if (!rst && aw_pop != 4'b0000) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", 32'(aw_pop), 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_aw_pop", 32'(aw_pop), 32'(oh(sb_e)));
                chk("sb_awid", 32'(awid), 32'(sb_e + 1));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          exp1[4];
        logic [31:0] exp_out;
        logic [7:0]  pc[4];
        logic [3:0]  hold_vals[5];
        int          k;

        rst         = 1'b1;
        req_valid   = 4'b0000;
        awready     = 1'b0;
        w_beat_last = 1'b0;
        b_done      = 1'b0;
        b_tag       = 3'd0;
        repeat (2) tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // 1: all ports requesting, awready high, no B.
`ifdef AW_SCHED_PRIO_EN
        exp1 = '{0, 0, 0, 0};
`else
        exp1 = '{0, 1, 2, 3};
`endif
        pc = '{8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 4; i++) begin
            push_exp(exp1[i]);
            pc[exp1[i]] = pc[exp1[i]] + 8'd1;
        end
        exp_out = {pc[3], pc[2], pc[1], pc[0]};
        req_valid = 4'b1111;
        awready   = 1'b1;
        tick();
        chk("t1_first_awvalid", 32'(awvalid), 32'd1);
        chk("t1_first_awid", 32'(awid), 32'(exp1[0] + 1));
        chk("t1_first_aw_sel", 32'(aw_sel), 32'(exp1[0]));
        repeat (7) tick();
        repeat (2) tick();
        chk("t1_oq_full_blocks", 32'(awvalid), 32'd0);
        chk("t1_outstanding", outstanding, exp_out);
        chk("t1_w_sel_head", 32'(w_sel), 32'(oh(exp1[0])));
        req_valid   = 4'b0000;
        w_beat_last = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t1_w_sel_drain", 32'(w_sel), (i < 4) ? 32'(oh(exp1[i])) : 32'd0);
        end
        w_beat_last = 1'b0;
        b_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_tag = 3'(exp1[i] + 1);
            tick();
        end
        b_done = 1'b0;
        chk("t1_b_return", outstanding, 32'd0);
        chk("t1_err", 32'(err_sticky), 32'd0);

        // 2: port b alone until its budget is exhausted.
        for (int i = 0; i < 8; i++) push_exp(1);
        req_valid = 4'b0010;
        run_drain(20);
        chk("t2_cnt_b_max", outstanding, 32'h0000_0800);
        chk("t2_throttled", 32'(awvalid), 32'd0);
        chk("t2_w_empty", 32'(w_sel), 32'd0);
        repeat (3) tick();
        chk("t2_still_throttled", 32'(awvalid), 32'd0);
        push_exp(1);
        b_done = 1'b1;
        b_tag  = 3'd2;
        tick();
        b_done = 1'b0;
        chk("t2_cnt_after_b", outstanding, 32'h0000_0700);
        k = 0;
        while (awvalid !== 1'b1 && k < 2) begin
            tick();
            k++;
        end
        chk("t2_reoffer", 32'(awvalid), 32'd1);
        req_valid = 4'b0000;
        tick();
        w_beat_last = 1'b1;
        tick();
        w_beat_last = 1'b0;
        chk("t2_w_empty_end", 32'(w_sel), 32'd0);
        b_done = 1'b1;
        b_tag  = 3'd2;
        repeat (8) tick();
        b_done = 1'b0;
        chk("t2_b_return", outstanding, 32'd0);

        // 3: offer held under backpressure while req_valid wanders.
        hold_vals = '{4'b0000, 4'b1111, 4'b0011, 4'b1000, 4'b0101};
        awready   = 1'b0;
        req_valid = 4'b0100;
        tick();
        chk("t3_awvalid", 32'(awvalid), 32'd1);
        chk("t3_awid", 32'(awid), 32'd3);
        for (int i = 0; i < 5; i++) begin
            req_valid = hold_vals[i];
            tick();
            chk("t3_hold_awvalid", 32'(awvalid), 32'd1);
            chk("t3_hold_awid", 32'(awid), 32'd3);
            chk("t3_hold_aw_sel", 32'(aw_sel), 32'd2);
            chk("t3_hold_no_pop", 32'(aw_pop), 32'd0);
        end
        push_exp(2);
        awready   = 1'b1;
        req_valid = 4'b0000;
        #1;
        chk("t3_release_pop", 32'(aw_pop), 32'b0100);
        tick();
        chk("t3_after_release", 32'(awvalid), 32'd0);
        tick();
        chk("t3_no_second_offer", 32'(awvalid), 32'd0);
        w_beat_last = 1'b1;
        tick();
        w_beat_last = 1'b0;
        b_done = 1'b1;
        b_tag  = 3'd3;
        tick();
        b_done = 1'b0;

        // 4: W ownership order, then simultaneous push and pop.
        push_exp(2);
        req_valid = 4'b0100;
        tick();
        push_exp(0);
        req_valid = 4'b0001;
        tick();
        chk("t4_w_sel_c", 32'(w_sel), 32'b0100);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("t4_w_sel_c_hold", 32'(w_sel), 32'b0100);
        w_beat_last = 1'b1;
        tick();
        chk("t4_w_sel_a", 32'(w_sel), 32'b0001);
        tick();
        chk("t4_w_sel_empty", 32'(w_sel), 32'd0);
        w_beat_last = 1'b0;
        push_exp(1);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        tick();
        chk("t4_w_sel_b", 32'(w_sel), 32'b0010);
        push_exp(3);
        req_valid = 4'b1000;
        tick();
        req_valid   = 4'b0000;
        w_beat_last = 1'b1;
        tick();
        w_beat_last = 1'b0;
        chk("t4_push_pop_same", 32'(w_sel), 32'b1000);
        w_beat_last = 1'b1;
        tick();
        w_beat_last = 1'b0;
        chk("t4_final_empty", 32'(w_sel), 32'd0);
        chk("t4_err", 32'(err_sticky), 32'd0);
        b_done = 1'b1;
        b_tag = 3'd3; tick();
        b_tag = 3'd1; tick();
        b_tag = 3'd2; tick();
        b_tag = 3'd4; tick();
        b_done = 1'b0;
        chk("t4_b_return", outstanding, 32'd0);

        // 5: error cases and reset in the middle of an offer.
        b_done = 1'b1;
        b_tag  = 3'd3;
        tick();
        b_done = 1'b0;
        chk("t5_underflow_cnt", outstanding, 32'd0);
        chk("t5_underflow_err", 32'(err_sticky), 32'd1);
        awready   = 1'b0;
        req_valid = 4'b0001;
        tick();
        chk("t5_offer", 32'(awvalid), 32'd1);
        rst = 1'b1;
        tick();
        chk_idle_outputs("t5_rst");
        rst       = 1'b0;
        req_valid = 4'b0000;
        awready   = 1'b1;
        tick();
        b_done = 1'b1;
        b_tag  = 3'd5;
        tick();
        b_done = 1'b0;
        chk("t5_bad_tag_err", 32'(err_sticky), 32'd1);
        chk("t5_bad_tag_cnt", outstanding, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_err_cleared", 32'(err_sticky), 32'd0);
        w_beat_last = 1'b1;
        tick();
        w_beat_last = 1'b0;
        chk("t5_wlast_empty_err", 32'(err_sticky), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

`ifdef AW_SCHED_PRIO_EN
        // 6: port a dominates, then b..d rotate once a drops out.
        for (int i = 0; i < 6; i++) push_exp(0);
        push_exp(1);
        push_exp(2);
        push_exp(3);
        req_valid = 4'b1111;
        run_drain(12);
        req_valid = 4'b1110;
        run_drain(6);
        req_valid = 4'b0000;
        run_drain(4);
        chk("t6_outstanding", outstanding, 32'h0101_0106);
`endif

        tick();
        chk("sb_all_consumed", 32'(exp_q.size()), 32'd0);
        chk("sb_pop_count", 32'(n_pops), 32'(n_pushed));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
